// File: rtl/sq_recip_counter.sv
// sq_recip_counter: reciprocal frequency / duty measurement core.
// Window opens and closes on rising edges of the filtered square wave.
module sq_recip_counter (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        sq_sig_filter,
  input  logic        start,
  input  logic [31:0] gate_len,
  input  logic [31:0] timeout_len,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] sig_cnt,
  output logic [31:0] ref_cnt,
  output logic [31:0] high_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    DONE
  } state_t;

  state_t      state;
  state_t      state_d;
  logic        prev;
  logic        rise;
  logic        tmo_hit;
  logic        closing;
  logic [31:0] gate_q;
  logic [31:0] gate_d;
  logic [31:0] tmo_q;
  logic [31:0] tmo_d;
  logic [31:0] r;
  logic [31:0] r_d;
  logic [31:0] h;
  logic [31:0] h_d;
  logic [31:0] s;
  logic [31:0] s_d;
  logic [31:0] g;
  logic [31:0] g_d;
  logic [31:0] t;
  logic [31:0] t_d;
  logic [31:0] t_inc;
  logic [31:0] sig_d;
  logic [31:0] ref_d;
  logic [31:0] high_d;
  logic        timeout_d;

  assign rise    = sq_sig_filter & ~prev;
  assign t_inc   = t + 32'd1;
  assign tmo_hit = (tmo_q != 32'd0) && (t_inc == tmo_q);
  assign closing = rise && (g >= gate_q);
  assign busy    = (state == ARM) || (state == MEAS);
  assign done    = (state == DONE);

  // State register and all datapath registers.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prev     <= 1'b0;
      gate_q   <= '0;
      tmo_q    <= '0;
      r        <= '0;
      h        <= '0;
      s        <= '0;
      g        <= '0;
      t        <= '0;
      sig_cnt  <= '0;
      ref_cnt  <= '0;
      high_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      prev     <= sq_sig_filter;
      gate_q   <= gate_d;
      tmo_q    <= tmo_d;
      r        <= r_d;
      h        <= h_d;
      s        <= s_d;
      g        <= g_d;
      t        <= t_d;
      sig_cnt  <= sig_d;
      ref_cnt  <= ref_d;
      high_cnt <= high_d;
      timeout  <= timeout_d;
    end
  end

  // Next state, window counters and result capture.
  always_comb begin
    state_d   = state;
    gate_d    = gate_q;
    tmo_d     = tmo_q;
    r_d       = r;
    h_d       = h;
    s_d       = s;
    g_d       = g;
    t_d       = t;
    sig_d     = sig_cnt;
    ref_d     = ref_cnt;
    high_d    = high_cnt;
    timeout_d = timeout;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          gate_d  = gate_len;
          tmo_d   = timeout_len;
          r_d     = '0;
          h_d     = '0;
          s_d     = '0;
          g_d     = '0;
          t_d     = '0;
        end
      end
      ARM: begin
        if (rise) begin
          state_d = MEAS;
          r_d     = 32'd1;
          h_d     = 32'd1;
          s_d     = '0;
          g_d     = 32'd1;
          t_d     = '0;
        end else begin
          t_d = t_inc;
          if (tmo_hit) begin
            state_d   = DONE;
            sig_d     = '0;
            ref_d     = '0;
            high_d    = '0;
            timeout_d = 1'b1;
          end
        end
      end
      MEAS: begin
        if (closing) begin
          state_d   = DONE;
          sig_d     = s + 32'd1;
          ref_d     = r;
          high_d    = h;
          timeout_d = 1'b0;
        end else if ((!rise && tmo_hit) || (r == '1)) begin
          // Edge gap too long, or the window would overflow.
          state_d   = DONE;
          sig_d     = '0;
          ref_d     = '0;
          high_d    = '0;
          timeout_d = 1'b1;
        end else begin
          r_d = r + 32'd1;
          h_d = h + {31'd0, sq_sig_filter};
          g_d = (g == '1) ? g : g + 32'd1;
          if (rise) begin
            s_d = s + 32'd1;
            t_d = '0;
          end else begin
            t_d = t_inc;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
